// File: rtl/hdmi_in_core.sv
// hdmi_in_core
//   Receive-side video timing core. Consumes the decoded pixel stream from the
//   TMDS decoder, learns the sync polarities, measures the active resolution and
//   locks once LOCK_FRAMES consecutive frames measure identically (LOCK_FRAMES
//   is expected to be 2 or more). While locked it streams pixels to the capture
//   FIFO with frame, line and chunk strobes for the downstream memory writer.
//
// Ports
//   clock            in   pixel clock, rising edge
//   reset            in   synchronous, active-high
//   start            in   enable; low behaves exactly as reset
//   ve               in   data enable (active video)
//   hsync, vsync     in   syncs of either polarity
//   red/green/blue   in   8-bit pixel components, valid when ve=1
//   pixel_data       out  {red,green,blue,8'h00}, one cycle after the inputs
//   write_fifo       out  pixel_data is to be written (locked only)
//   frame_start      out  first written pixel of a frame
//   line_start       out  first written pixel of each line
//   write_next_chunk out  written pixel whose index is a multiple of CHUNK
//   hcount, vcount   out  pixel / line index of pixel_data
//   hres_detected    out  measured active pixels per line
//   vres_detected    out  measured active lines per frame
//   locked           out  measurement stable, capture enabled
module hdmi_in_core #(
  parameter int LOCK_FRAMES = 3,
  parameter int CHUNK       = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        ve,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [7:0]  red,
  input  logic [7:0]  green,
  input  logic [7:0]  blue,
  output logic [31:0] pixel_data,
  output logic        write_fifo,
  output logic        frame_start,
  output logic        line_start,
  output logic        write_next_chunk,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic [10:0] hres_detected,
  output logic [10:0] vres_detected,
  output logic        locked
);

  localparam logic [10:0]   SAT_MAX    = 11'h7FF;
  localparam logic [10:0]   CHUNK_MASK = 11'(CHUNK - 1);
  localparam int            SW         = $clog2(LOCK_FRAMES + 1);
  localparam logic [SW-1:0] STABLE_ONE = SW'(1);
  localparam logic [SW-1:0] LOCK_N     = SW'(LOCK_FRAMES);

  typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_VERIFY, S_LOCKED} state_t;

  // Saturating counter step: a counter that reaches 2047 sticks there.
  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == SAT_MAX) ? v : v + 11'd1;
  endfunction

  state_t        state_q, state_d;
  logic          ve_q, ve_d;
  logic          vs_act_q, vs_act_d;
  logic          pol_known_q, pol_known_d;
  logic          hs_idle_q, hs_idle_d;
  logic          vs_idle_q, vs_idle_d;
  logic [10:0]   run_len_q, run_len_d;
  logic [10:0]   line_cnt_q, line_cnt_d;
  logic [10:0]   first_w_q, first_w_d;
  logic          consistent_q, consistent_d;
  logic [10:0]   stored_w_q, stored_w_d;
  logic [10:0]   stored_h_q, stored_h_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [31:0]   pixel_q, pixel_d;
  logic          write_q, write_d;
  logic          fs_q, fs_d;
  logic          ls_q, ls_d;
  logic          wc_q, wc_d;
  logic [10:0]   hcount_q, hcount_d;
  logic [10:0]   vcount_q, vcount_d;

  logic hs_act, vs_act, vs_edge, ve_fall, cap, frame_ok, frame_match;

  // A sync is active when it differs from the level seen during active video.
  assign hs_act  = hsync ^ hs_idle_q;
  assign vs_act  = vsync ^ vs_idle_q;
  assign vs_edge = pol_known_q & vs_act & ~vs_act_q;
  assign ve_fall = ve_q & ~ve;
  assign cap     = ve & (state_q == S_LOCKED);

  // Saturated or empty measurements never match, so they can never lock.
  assign frame_ok    = consistent_q && (line_cnt_q != 11'd0) && (line_cnt_q != SAT_MAX);
  assign frame_match = frame_ok && (first_w_q == stored_w_q) && (line_cnt_q == stored_h_q);

  always_comb begin
    state_d      = state_q;
    ve_d         = ve;
    vs_act_d     = vs_act;
    pol_known_d  = pol_known_q;
    hs_idle_d    = hs_idle_q;
    vs_idle_d    = vs_idle_q;
    line_cnt_d   = line_cnt_q;
    first_w_d    = first_w_q;
    consistent_d = consistent_q;
    stored_w_d   = stored_w_q;
    stored_h_d   = stored_h_q;
    stable_d     = stable_q;

    // Learn idle sync levels during active video, but never from a cycle in
    // which a sync is already known to be active.
    if (ve && !(pol_known_q && (hs_act || vs_act))) begin
      hs_idle_d   = hsync;
      vs_idle_d   = vsync;
      pol_known_d = 1'b1;
    end

    run_len_d = ve ? sat_inc(run_len_q) : 11'd0;

    // On the falling edge of ve, run_len_q holds the width of the line just ended.
    if (ve_fall) begin
      line_cnt_d = sat_inc(line_cnt_q);
      if (line_cnt_q == 11'd0) begin
        first_w_d = run_len_q;
      end else if (run_len_q != first_w_q) begin
        consistent_d = 1'b0;
      end
      if (run_len_q == SAT_MAX) begin
        consistent_d = 1'b0;
      end
    end

    // Frame boundary: evaluate the completed frame and restart measurement.
    if (vs_edge) begin
      line_cnt_d   = 11'd0;
      consistent_d = 1'b1;
      unique case (state_q)
        S_IDLE: state_d = S_MEASURE;
        S_MEASURE: begin
          stored_w_d = first_w_q;
          stored_h_d = line_cnt_q;
          stable_d   = STABLE_ONE;
          state_d    = S_VERIFY;
        end
        S_VERIFY: begin
          if (frame_match) begin
            stable_d = stable_q + STABLE_ONE;
            if (stable_q + STABLE_ONE == LOCK_N) begin
              state_d = S_LOCKED;
            end
          end else begin
            stored_w_d = first_w_q;
            stored_h_d = line_cnt_q;
            stable_d   = STABLE_ONE;
          end
        end
        S_LOCKED: begin
          if (!frame_match) begin
            state_d = S_MEASURE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    pixel_d  = {red, green, blue, 8'h00};
    write_d  = cap;
    hcount_d = run_len_q;
    vcount_d = line_cnt_q;
    fs_d     = cap && (run_len_q == 11'd0) && (line_cnt_q == 11'd0);
    ls_d     = cap && (run_len_q == 11'd0);
    wc_d     = cap && ((run_len_q & CHUNK_MASK) == 11'd0);
  end

  always_ff @(posedge clock) begin
    if (reset || !start) begin
      state_q      <= S_IDLE;
      ve_q         <= 1'b0;
      vs_act_q     <= 1'b0;
      pol_known_q  <= 1'b0;
      hs_idle_q    <= 1'b0;
      vs_idle_q    <= 1'b0;
      run_len_q    <= '0;
      line_cnt_q   <= '0;
      first_w_q    <= '0;
      consistent_q <= 1'b0;
      stored_w_q   <= '0;
      stored_h_q   <= '0;
      stable_q     <= '0;
      pixel_q      <= '0;
      write_q      <= 1'b0;
      fs_q         <= 1'b0;
      ls_q         <= 1'b0;
      wc_q         <= 1'b0;
      hcount_q     <= '0;
      vcount_q     <= '0;
    end else begin
      state_q      <= state_d;
      ve_q         <= ve_d;
      vs_act_q     <= vs_act_d;
      pol_known_q  <= pol_known_d;
      hs_idle_q    <= hs_idle_d;
      vs_idle_q    <= vs_idle_d;
      run_len_q    <= run_len_d;
      line_cnt_q   <= line_cnt_d;
      first_w_q    <= first_w_d;
      consistent_q <= consistent_d;
      stored_w_q   <= stored_w_d;
      stored_h_q   <= stored_h_d;
      stable_q     <= stable_d;
      pixel_q      <= pixel_d;
      write_q      <= write_d;
      fs_q         <= fs_d;
      ls_q         <= ls_d;
      wc_q         <= wc_d;
      hcount_q     <= hcount_d;
      vcount_q     <= vcount_d;
    end
  end

  assign pixel_data       = pixel_q;
  assign write_fifo       = write_q;
  assign frame_start      = fs_q;
  assign line_start       = ls_q;
  assign write_next_chunk = wc_q;
  assign hcount           = hcount_q;
  assign vcount           = vcount_q;
  assign hres_detected    = stored_w_q;
  assign vres_detected    = stored_h_q;
  assign locked           = (state_q == S_LOCKED);

endmodule
